// File: rtl/spi_cmd_master.sv
// SPI mode-0 master that shifts out a framed command (CMD, ADDR, DATA3..0)
// and collects the slave's MISO bits into a 32-bit readback word.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start, CS high
// SETUP | CS low, first MOSI bit presented, SCLK low
// HIGH  | SCLK high; MISO captured on entry
// LOW   | SCLK low; next MOSI bit shifted out on entry
// HOLD  | SCLK low after the final bit, CS still low
// GAP   | CS high inter-frame gap; Done on first cycle, Busy held
module spi_cmd_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [7:0]  Cmd,
    input  logic [7:0]  Addr,
    input  logic [31:0] Data,
    input  logic [2:0]  Len,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RxData,
    output logic        SCLK,
    output logic        MOSI,
    output logic        CS,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [47:0] tx_sr;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [2:0]  len_q;
    logic [15:0] tmr;
    logic [2:0]  len_eff;
    logic        tmr_tc;
    logic        last_bit;

    always_comb begin
        len_eff = (Len == 3'd7) ? 3'd6 : Len;
    end

    assign tmr_tc   = (tmr == 16'd0);
    // Final bit: the increment about to happen wraps the bit counter and
    // brings the byte counter up to the frame length.
    assign last_bit = (bit_cnt == 3'd7) && ((byte_cnt + 3'd1) == len_q);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            tmr      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            RxData   <= '0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            CS       <= 1'b1;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (len_eff == 3'd0) begin
                            Done <= 1'b1;
                        end else begin
                            tx_sr    <= {Cmd, Addr, Data};
                            len_q    <= len_eff;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            tmr      <= DIV_LOAD;
                            CS       <= 1'b0;
                            Busy     <= 1'b1;
                            MOSI     <= Cmd[7];
                            state    <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    MOSI <= tx_sr[47];
                    if (tmr_tc) begin
                        SCLK   <= 1'b1;
                        RxData <= {RxData[30:0], MISO};
                        tmr    <= DIV_LOAD;
                        state  <= S_HIGH;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                S_HIGH: begin
                    if (tmr_tc) begin
                        SCLK    <= 1'b0;
                        tmr     <= DIV_LOAD;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                        if (last_bit) begin
                            state <= S_HOLD;
                        end else begin
                            tx_sr <= {tx_sr[46:0], 1'b0};
                            MOSI  <= tx_sr[46];
                            state <= S_LOW;
                        end
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                S_LOW: begin
                    if (tmr_tc) begin
                        SCLK   <= 1'b1;
                        RxData <= {RxData[30:0], MISO};
                        tmr    <= DIV_LOAD;
                        state  <= S_HIGH;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                S_HOLD: begin
                    if (tmr_tc) begin
                        CS    <= 1'b1;
                        MOSI  <= 1'b0;
                        Done  <= 1'b1;
                        tmr   <= GAP_LOAD;
                        state <= S_GAP;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                S_GAP: begin
                    // Busy stays high through the whole gap so a new Start
                    // is only ever seen once the gap has fully elapsed.
                    if (tmr_tc) begin
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: a model slave answers on MISO, the
// driver queues expected frames and a bus monitor checks them at each Done.
module tb_spi_cmd_master;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  Cmd = '0;
    logic [7:0]  Addr = '0;
    logic [31:0] Data = '0;
    logic [2:0]  Len = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] RxData;
    logic        SCLK;
    logic        MOSI;
    logic        CS;
    logic        MISO = 1'b0;

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Cmd(Cmd), .Addr(Addr),
        .Data(Data), .Len(Len), .Busy(Busy), .Done(Done), .RxData(RxData),
        .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          len;
        logic [47:0] bits;
        logic [31:0] rx;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rx_model = '0;
    logic [47:0] slave_resp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model slave: first bit presented when CS falls, next bit on each SCLK fall.
    logic sl_cs_q = 1'b1;
    logic sl_sclk_q = 1'b0;
    int   sl_idx = 0;
    always @(CS or SCLK) begin
        if (CS === 1'b0 && sl_cs_q === 1'b1) begin
            sl_idx = 0;
            MISO = slave_resp[47];
        end else if (CS === 1'b0 && SCLK === 1'b0 && sl_sclk_q === 1'b1) begin
            sl_idx++;
            MISO = (sl_idx < 48) ? slave_resp[47 - sl_idx] : 1'b0;
        end else if (CS === 1'b1) begin
            MISO = 1'b0;
        end
        sl_cs_q = CS;
        sl_sclk_q = SCLK;
    end

    // Bus monitor
    int          rises = 0;
    int          cs_low = 0;
    int          done_cnt = 0;
    logic [47:0] cap = '0;
    logic        mosi_bad = 1'b0;
    logic        sclk_prev = 1'b0;
    logic        mosi_prev = 1'b0;
    logic        done_prev = 1'b0;
    exp_t        e_mon;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            rises = 0;
            cs_low = 0;
            cap = '0;
            mosi_bad = 1'b0;
        end else begin
            if (CS === 1'b0) cs_low++;
            if (SCLK === 1'b1 && sclk_prev === 1'b0) begin
                rises++;
                cap = {cap[46:0], MOSI};
            end
            if (SCLK === 1'b1 && sclk_prev === 1'b1 && MOSI !== mosi_prev) mosi_bad = 1'b1;
            if (Done === 1'b1) begin
                done_cnt++;
                chk("done_single_pulse", 64'(done_prev), 64'(0));
                chk("sb_nonempty_at_done", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    chk("sclk_rises", 64'(rises), 64'(8 * e_mon.len));
                    chk("cs_low_cycles", 64'(cs_low),
                        64'(e_mon.len == 0 ? 0 : CLK_DIV * (16 * e_mon.len + 1)));
                    chk("mosi_bits", 64'(cap), 64'(e_mon.bits));
                    chk("rxdata", 64'(RxData), 64'(e_mon.rx));
                    chk("mosi_stable_high", 64'(mosi_bad), 64'(0));
                end
                rises = 0;
                cs_low = 0;
                cap = '0;
                mosi_bad = 1'b0;
            end
        end
        sclk_prev = SCLK;
        mosi_prev = MOSI;
        done_prev = Done;
    end

    function automatic logic [47:0] tx_bits(input logic [7:0] c, input logic [7:0] a,
                                            input logic [31:0] d, input int le);
        logic [47:0] full;
        full = {c, a, d};
        return full >> (48 - 8 * le);
    endfunction

    task automatic issue(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                         input logic [2:0] l, input logic [47:0] resp, input bit push);
        exp_t e;
        int   le;
        le = (l == 3'd7) ? 6 : int'(l);
        if (push) begin
            slave_resp = resp;
            for (int b = 0; b < le; b++) rx_model = {rx_model[23:0], resp[47 - 8 * b -: 8]};
            e.len  = le;
            e.bits = tx_bits(c, a, d, le);
            e.rx   = rx_model;
            sb.push_back(e);
        end
        Cmd = c; Addr = a; Data = d; Len = l; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        Cmd = 8'($urandom); Addr = 8'($urandom); Data = $urandom; Len = 3'($urandom);
    endtask

    task automatic wait_done(input int le);
        int n;
        int b;
        n = 0;
        while (Done !== 1'b1 && n < 3000) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("done_seen", 64'(Done), 64'(1));
        if (Done !== 1'b1) return;
        chk("busy_at_done", 64'(Busy), 64'(le > 0));
        chk("cs_high_at_done", 64'(CS), 64'(1));
        chk("mosi_low_at_done", 64'(MOSI), 64'(0));
        if (le > 0) begin
            b = 0;
            while (Busy === 1'b1 && b < 1000) begin
                b++;
                @(posedge Clk); #1;
            end
            chk("busy_gap_cycles", 64'(b), 64'(GAP_CYCLES));
        end
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                         input logic [2:0] l, input logic [47:0] resp);
        issue(c, a, d, l, resp, 1'b1);
        wait_done((l == 3'd7) ? 6 : int'(l));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          d0;
        logic [47:0] r;
        logic [31:0] rx_before;

        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        chk("reset_cs", 64'(CS), 64'(1));
        chk("reset_sclk", 64'(SCLK), 64'(0));
        chk("reset_mosi", 64'(MOSI), 64'(0));
        chk("reset_busy", 64'(Busy), 64'(0));
        chk("reset_done", 64'(Done), 64'(0));
        chk("reset_rxdata", 64'(RxData), 64'(0));

        frame(8'h02, 8'h01, 32'h0, 3'd2, {16'($urandom), $urandom});
        frame(8'h0D, 8'h00, 32'hA5C3_0F81, 3'd6, {16'($urandom), $urandom});
        frame(8'h07, 8'h00, 32'h0, 3'd6, {16'h1234, 32'hDEAD_BEEF});
        chk("rx_deadbeef", 64'(RxData), 64'(32'hDEAD_BEEF));

        frame(8'h05, 8'h33, 32'h1111_2222, 3'd0, 48'h0);
        chk("len0_rx_unchanged", 64'(RxData), 64'(32'hDEAD_BEEF));

        frame(8'h09, 8'h44, 32'h0, 3'd1, {8'h5A, 40'h0});
        chk("len1_rx_shift", 64'(RxData), 64'(32'hADBE_EF5A));

        frame(8'($urandom), 8'($urandom), $urandom, 3'd7, {16'($urandom), $urandom});

        // Start mid-frame with a different command must be ignored.
        issue(8'hC1, 8'h22, 32'h8765_4321, 3'd4, {16'($urandom), $urandom}, 1'b1);
        repeat (60) @(posedge Clk);
        #1;
        issue(8'h3E, 8'h99, 32'hFFFF_0000, 3'd6, 48'h0, 1'b0);
        wait_done(4);

        for (int i = 0; i < 8; i++) begin
            frame(8'($urandom), 8'($urandom), $urandom, 3'($urandom_range(0, 7)),
                  {16'($urandom), $urandom});
        end

        // Reset while byte index 2 of a 6-byte frame is on the wire.
        r = {16'($urandom), $urandom};
        rx_before = rx_model;
        issue(8'h4B, 8'h10, $urandom, 3'd6, r, 1'b1);
        n = 0;
        while (rises < 20 && n < 3000) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("abort_reached_byte3", 64'(rises >= 20), 64'(1));
        d0 = done_cnt;
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        chk("abort_cs", 64'(CS), 64'(1));
        chk("abort_sclk", 64'(SCLK), 64'(0));
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_done", 64'(Done), 64'(0));
        chk("abort_rxdata", 64'(RxData), 64'(0));
        Rst_n = 1'b1;
        sb.delete();
        rx_model = '0;
        repeat (40) @(posedge Clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        chk("abort_rx_was_live", 64'(rx_before != 32'h0 || r != 48'h0), 64'(1));

        frame(8'h01, 8'h02, 32'h0, 3'd0, 48'h0);
        repeat (5) @(posedge Clk);
        #1;
        chk("len0_cs_idle", 64'(CS), 64'(1));
        chk("len0_sb_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI master that issues framed command transactions to the shield's SPI command slave.
- Frame format on the wire: COMMAND, ADDRESS, then optional DATA0..DATA3 (MSB byte first).
- Used by the test/host-side FPGA logic to drive register reads/writes (LED, PWM, pin mode, terminate count).
- Captures the slave's MISO response bytes into a 32-bit readback word.

Parameters:
CLK_DIV, 4, Clk cycles per SCLK half-period (legal 2..255)
GAP_CYCLES, 8, minimum Clk cycles CS stays high between frames

Ports:
Clk  in  1  system clock
Rst_n  in  1  synchronous active-low reset
Start  in  1  one-cycle request; sampled only when Busy=0
Cmd  in  8  command byte (byte 0)
Addr  in  8  address/operand byte (byte 1)
Data  in  32  payload; Data[31:24] is byte 2 … Data[7:0] is byte 5
Len  in  3  bytes in frame, 1..6
Busy  out  1  transaction in progress
Done  out  1  one-cycle pulse at frame completion
RxData  out  32  last four MISO bytes received, most recent in [7:0]
SCLK  out  1  SPI clock, mode 0 (idle low)
MOSI  out  1  SPI data out, MSB first
CS  out  1  chip select, active low
MISO  in  1  SPI data in

Behaviour:
- Reset (Rst_n=0 at a Clk edge): state IDLE, CS=1, SCLK=0, MOSI=0, Busy=0, Done=0, RxData=0, all counters 0. Reset mid-frame aborts immediately (CS high the next cycle), with no Done pulse.
- Start accepted in IDLE only:
  - Latch Cmd/Addr/Data/Len into a 48-bit TX shift register and byte count.
  - Busy=1 and CS=0 from the next cycle.
  - Start while Busy is ignored (no queueing).
- Len clamp:
  - Len=0 → no frame. CS stays high, Done pulses one cycle after Start, Busy never asserts, RxData unchanged.
  - Len=7 → treated as 6.
- States:
  - IDLE: waiting for Start.
  - SETUP: CS low, SCLK low, MOSI=bit 47 of TX register; lasts CLK_DIV cycles.
  - HIGH: SCLK=1 for CLK_DIV cycles. MISO is sampled on the cycle SCLK rises and shifted into RxData LSB.
  - LOW: SCLK=0 for CLK_DIV cycles. On entry, the TX register shifts left and MOSI updates. Not entered after the final bit.
  - HIGH/LOW alternate for Len×8 bits. After the final HIGH, go to HOLD.
  - HOLD: SCLK=0, CS low for CLK_DIV cycles.
  - GAP: CS=1 for GAP_CYCLES cycles. Done pulses on the first GAP cycle; Busy drops on the last GAP cycle.
- Bit/byte counting:
  - 3-bit bit counter wraps 7→0; byte counter increments on wrap.
  - The frame ends when the byte counter reaches Len with bit counter = 0.
- RxData:
  - Continuous 32-bit left shift of sampled MISO.
  - For Len<4, the upper bits retain the oldest prior contents shifted up.
  - RxData is stable from the Done pulse until the next accepted Start.
- Frame duration (Len=L, CS low): CLK_DIV + L×8×2×CLK_DIV − CLK_DIV + CLK_DIV = CLK_DIV×(16L+1) Clk cycles.
- MOSI holds its last bit through HOLD, then goes to 0 in GAP/IDLE.
- SCLK has no glitches; it toggles only on state transitions, which are registered outputs.

Test Plan:
- Reset then idle 20 cycles → CS=1, SCLK=0, MOSI=0, Busy=0, Done=0, RxData=0.
- Start with Cmd=0x02, Addr=0x01, Len=2, CLK_DIV=4 → loopback slave sees bytes 0x02,0x01. Requirements: 16 SCLK rising edges, CS low exactly 4×33=132 cycles, Done one pulse, Busy high until the end of GAP.
- Start with Cmd=0x0D, Addr=0x00, Data=0xA5C3_0F81, Len=6 → bytes 02..: 0x0D,0x00,0xA5,0xC3,0x0F,0x81 on MOSI, MSB first, each changing only while SCLK=0.
- Model slave returns 0xDEADBEEF on bytes 2..5 of a 6-byte frame for Cmd=0x07 → RxData=0xDEADBEEF at the Done pulse.
- Start pulsed again mid-frame with different Cmd → ignored; the frame completes with the original bytes. A Start on the cycle after Busy falls is accepted.
- Rst_n low during byte 3 of a 6-byte frame → CS=1 and SCLK=0 next cycle, no Done. Len=0 Start → Done next cycle, CS never falls.
